// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared types and constants for the UART transmitter and receiver.
//   tx_state_e        : transmitter FSM state encoding (logic [2:0])
//   DEFAULT_DIV_RATIO : clocks per bit for 100 MHz / 115.2 kbaud
//   UART_DATA_W       : data bits per frame
//   calc_parity()     : parity bit for a data byte, even (odd=0) or odd (odd=1)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned DEFAULT_DIV_RATIO = 868;
  localparam int unsigned UART_DATA_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic logic calc_parity(input logic [UART_DATA_W-1:0] data,
                                       input logic                   odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if -- byte handshake between a producer core and uart_tx.
//   tx_data  : byte to send, sampled when tx_valid && tx_ready
//   tx_valid : producer has a byte
//   tx_ready : transmitter holding register is empty
// Modports: master = producer, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen -- bit-period counter.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   en   : count enable; counter held at zero while low
//   tick : one-cycle pulse when the count reaches div_ratio-1
// The counter runs 0..div_ratio-1 and wraps, so consecutive ticks are exactly
// div_ratio clocks apart with no cumulative drift.
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned div_ratio = DEFAULT_DIV_RATIO
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned    CNT_W = $clog2(div_ratio);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(div_ratio - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmitter, 8 data bits LSB first, idle-high line.
//   clk     : system clock
//   rst     : asynchronous active-high reset (aborts any frame in progress)
//   tx      : uart_tx_if.slave byte handshake (tx_data / tx_valid / tx_ready)
//   tx_line : registered serial output, idle 1
//   busy    : high from start bit through the last stop bit
// Parameters: div_ratio (clocks per bit, >= 2), stop_bits (1 or 2),
//             parity_odd (0 even / 1 odd, used only with parity enabled).
// Build option: define UART_TX_PARITY_EN to insert a parity bit after bit 7.
//
// A one-byte holding register in front of the shift register lets the next
// frame start on the clock right after the previous stop bit ends.
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned div_ratio  = DEFAULT_DIV_RATIO,
  parameter int unsigned stop_bits  = 1,
  parameter int unsigned parity_odd = 0
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   tx,
  output logic       tx_line,
  output logic       busy
);

  if (div_ratio < 2 || (stop_bits != 1 && stop_bits != 2) || parity_odd > 1) begin : g_bad_cfg
    $error("uart_tx: illegal parameter combination");
  end

  tx_state_e              state_q;
  logic [UART_DATA_W-1:0] hold_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic                   hold_full_q;
  logic                   ready_q;
  logic                   line_q;
  logic                   busy_q;
  logic [2:0]             bit_cnt_q;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  logic tick;
  logic baud_en;
  logic xfer;
  logic stop_done;
  logic load;
  logic hold_full_d;

  assign baud_en = (state_q != ST_IDLE);

  uart_baud_gen #(.div_ratio(div_ratio)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (baud_en),
    .tick (tick)
  );

  assign xfer      = tx.tx_valid && ready_q;
  // In STOP the bit counter counts stop bits; it is 0 on entry because it
  // wrapped 7->0 leaving DATA.
  assign stop_done = (state_q == ST_STOP) && tick && (bit_cnt_q == 3'(stop_bits - 1));
  assign load      = hold_full_q && ((state_q == ST_IDLE) || stop_done);
  // A transfer coinciding with a load refills the slot the load just emptied.
  assign hold_full_d = xfer || (hold_full_q && !load);

  // Outputs are registered from the current state, so the line lags the FSM
  // by one clock uniformly; frame timing is unaffected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      line_q      <= 1'b1;
      busy_q      <= 1'b0;
      bit_cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        hold_q <= tx.tx_data;
      end
      hold_full_q <= hold_full_d;
      ready_q     <= !hold_full_d;
      busy_q      <= (state_q != ST_IDLE);

      case (state_q)
        ST_IDLE: begin
          line_q <= 1'b1;
          if (load) begin
            state_q <= ST_START;
          end
        end
        ST_START: begin
          line_q <= 1'b0;
          if (tick) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          line_q <= shift_q[0];
          if (tick) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          line_q <= par_q;
          if (tick) begin
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          line_q <= 1'b1;
          if (stop_done) begin
            bit_cnt_q <= '0;
            state_q   <= load ? ST_START : ST_IDLE;
          end else if (tick) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          line_q  <= 1'b1;
        end
      endcase

      // Load is only possible in IDLE or at the STOP end, never in DATA,
      // so this cannot collide with the shift above.
      if (load) begin
        shift_q <= hold_q;
`ifdef UART_TX_PARITY_EN
        par_q   <= calc_parity(hold_q, parity_odd != 0);
`endif
      end
    end
  end

  assign tx.tx_ready = ready_q;
  assign tx_line     = line_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- directed self-checking bench for uart_tx at div_ratio=8.
//   DUT 0: stop_bits=1, even parity; DUT 1: stop_bits=2; DUT 2: odd parity.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DIV = 8;

  logic clk;
  logic rst;
  logic la, ba, lb, bb, lc, bc;

  int nchk;
  int nerr;

  uart_tx_if ifa ();
  uart_tx_if ifb ();
  uart_tx_if ifc ();

  uart_tx #(.div_ratio(DIV), .stop_bits(1), .parity_odd(0)) dut_a (
    .clk(clk), .rst(rst), .tx(ifa.slave), .tx_line(la), .busy(ba));
  uart_tx #(.div_ratio(DIV), .stop_bits(2), .parity_odd(0)) dut_b (
    .clk(clk), .rst(rst), .tx(ifb.slave), .tx_line(lb), .busy(bb));
  uart_tx #(.div_ratio(DIV), .stop_bits(1), .parity_odd(1)) dut_c (
    .clk(clk), .rst(rst), .tx(ifc.slave), .tx_line(lc), .busy(bc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [7:0] d);
    case (s)
      0:       begin ifa.tx_valid = v; ifa.tx_data = d; end
      1:       begin ifb.tx_valid = v; ifb.tx_data = d; end
      default: begin ifc.tx_valid = v; ifc.tx_data = d; end
    endcase
  endtask

  task automatic samp(input int s, output logic l, output logic b, output logic r);
    @(negedge clk);
    case (s)
      0:       begin l = la; b = ba; r = ifa.tx_ready; end
      1:       begin l = lb; b = bb; r = ifb.tx_ready; end
      default: begin l = lc; b = bc; r = ifc.tx_ready; end
    endcase
  endtask

  task automatic expect_level(input int s, input logic lvl, input int n, input string tag);
    logic l, b, r;
    for (int i = 0; i < n; i++) begin
      samp(s, l, b, r);
      chk({tag, "_line"}, l, lvl);
      chk({tag, "_busy"}, b, 1'b1);
    end
  endtask

  task automatic expect_frame(input int s, input logic [7:0] d);
    int stop;
    stop = (s == 1) ? 2 : 1;
    expect_level(s, 1'b0, DIV, "start");
    for (int i = 0; i < 8; i++) expect_level(s, d[i], DIV, "data");
`ifdef UART_TX_PARITY_EN
    expect_level(s, (s == 2) ? ~^d : ^d, DIV, "parity");
`endif
    expect_level(s, 1'b1, DIV * stop, "stop");
  endtask

  task automatic expect_idle(input int s, input int n, input string tag);
    logic l, b, r;
    for (int i = 0; i < n; i++) begin
      samp(s, l, b, r);
      chk({tag, "_line"}, l, 1'b1);
      chk({tag, "_busy"}, b, 1'b0);
      chk({tag, "_ready"}, r, 1'b1);
    end
  endtask

  // Single byte: transfer at posedge N, line stays high through N+1, start
  // bit visible from N+2.
  task automatic send1(input int s, input logic [7:0] d);
    logic l, b, r;
    @(negedge clk);
    drive(s, 1'b1, d);
    @(posedge clk);
    #1 drive(s, 1'b0, d);
    samp(s, l, b, r);
    chk("lat0_ready", r, 1'b0);
    chk("lat0_line", l, 1'b1);
    chk("lat0_busy", b, 1'b0);
    samp(s, l, b, r);
    chk("lat1_ready", r, 1'b1);
    chk("lat1_line", l, 1'b1);
    chk("lat1_busy", b, 1'b0);
    expect_frame(s, d);
    expect_idle(s, 2, "post");
  endtask

  // Two bytes with tx_valid held high: second transfer at N+2.
  task automatic send2(input logic [7:0] b0, input logic [7:0] b1, input bit check);
    logic l, b, r;
    @(negedge clk);
    drive(0, 1'b1, b0);
    @(posedge clk);
    #1 drive(0, 1'b1, b1);
    samp(0, l, b, r);
    chk("pair_ready_full", r, 1'b0);
    @(posedge clk);
    samp(0, l, b, r);
    chk("pair_ready_free", r, 1'b1);
    chk("pair_line_idle", l, 1'b1);
    @(posedge clk);
    #1 drive(0, 1'b0, b1);
    chk("pair_ready_held", ifa.tx_ready, 1'b0);
    if (check) begin
      expect_frame(0, b0);
      expect_frame(0, b1);
      expect_idle(0, 2, "pair_post");
    end
  endtask

  initial begin
    logic [7:0] r0, r1;
    nchk = 0;
    nerr = 0;
    rst  = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", la, 1'b1);
    chk("rst_busy", ba, 1'b0);
    chk("rst_ready", ifa.tx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    expect_idle(0, 100, "idle");
    expect_idle(1, 1, "idle_b");

    send1(0, 8'h55);
    send2(8'hA3, 8'h0F, 1'b1);
    r0 = 8'($urandom_range(0, 255));
    r1 = 8'($urandom_range(0, 255));
    send2(r0, r1, 1'b1);
    send1(1, 8'hFF);
`ifdef UART_TX_PARITY_EN
    send1(0, 8'h07);
    send1(2, 8'h07);
`else
    send1(2, 8'h3C);
`endif

    // Reset mid-frame with a second byte still held: both must be dropped.
    send2(8'h00, 8'h81, 1'b0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_line", la, 1'b1);
    chk("midrst_busy", ba, 1'b0);
    chk("midrst_ready", ifa.tx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    expect_idle(0, 3 * 10 * DIV, "after_rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, 8N1 framing (8N2 or 8E1/8O1 when configured), LSB first, idle-high line.
- Counterpart of the team's UART receiver; shares its baud convention: div_ratio = f_clk / baud (100 MHz / 115.2 kbaud = 868).
- Sits between a byte-producing core (valid/ready handshake) and the FPGA TX pin.
- One-byte holding register allows back-to-back frames with no idle gap.

Parameters:
- div_ratio, 868, clocks per bit; legal range >= 2.
- stop_bits, 1, number of stop bits; legal values 1 or 2.
- parity_odd, 0, parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  holding register empty; byte accepted on this cycle's posedge if tx_valid.
- tx_line  output  1  serial output; registered, idle 1.
- busy  output  1  frame in progress (start bit through last stop bit).

Behaviour:
- Reset (async, active-high):
  - tx_line=1, busy=0, tx_ready=1.
  - Holding register empty; baud counter 0; state IDLE.
  - Reset mid-frame aborts the frame immediately: tx_line returns to 1 and any held byte is discarded.
- Handshake:
  - Transfer occurs on a posedge with tx_valid && tx_ready; tx_ready deasserts the next cycle.
  - tx_ready is a pure register output, never combinationally dependent on tx_valid.
  - tx_data may change freely when no transfer occurs.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: if the holding register is full, move the byte into the shift register, free the holding register (tx_ready=1 next cycle), and go to START.
  - Latency: transfer posedge N; holding register full at N+1; tx_line=0 and busy=1 from N+2.
  - START: tx_line=0 for div_ratio clocks, then DATA.
  - DATA: shift out bit0 first, each bit exactly div_ratio clocks; after bit7 go to PARITY or STOP.
  - STOP: tx_line=1 for stop_bits*div_ratio clocks.
  - At the STOP end: if the holding register is full, load it and enter START on the very next clock (zero idle gap); else go to IDLE with busy=0.
- Frame length: (1+8+stop_bits[+1 parity])*div_ratio clocks exactly; no jitter and no cumulative drift.
- Baud counter:
  - Width $clog2(div_ratio).
  - Counts 0..div_ratio-1 and wraps.
  - Bit-boundary tick when count==div_ratio-1.
  - Counter is held at 0 in IDLE.
- Bit counter: 3 bits; wraps 7->0 when leaving DATA.
- Simultaneous events: a transfer on the same posedge as a STOP-end load is legal. The byte being loaded comes from the old holding contents, and the new byte refills the holding register. tx_ready stays 0 in that case.
- An illegal state (default branch) returns to IDLE with tx_line=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after bit7 for div_ratio clocks.
  - Driven value is ^data for even parity; ~^data when parity_odd=1.
- Undefined: PARITY state and parity logic are absent; DATA goes directly to STOP.

Decomposition:
- Package uart_pkg holds:
  - the tx state enum (logic [2:0]);
  - DEFAULT_DIV_RATIO = 868;
  - UART_DATA_W = 8;
  - function calc_parity(data, odd).
- The same package is to be adopted by the receiver later.
- One natural sub-module: uart_baud_gen (parameter div_ratio; inputs clk, rst, en; output tick).
  - Held at zero while en=0; one-cycle tick at count div_ratio-1.
  - Reusable for the receiver's half-bit-offset sampling.

Test Plan (div_ratio=8, stop_bits=1 unless stated):
- Reset then idle 100 clocks -> tx_line=1, busy=0, tx_ready=1 throughout. Assert rst mid-frame -> tx_line=1 within the same cycle, busy=0, tx_ready=1.
- Send 0x55 -> tx_line 0,1,0,1,0,1,0,1,0,1, each level held 8 clocks. Frame spans 80 clocks. First 0 appears 2 clocks after the transfer.
- Send 0xA3 then 0x0F with tx_valid held high -> second start bit immediately follows the first stop bit (0-clock gap). tx_ready low while the holding register is full. Total 160 clocks busy.
- stop_bits=2, send 0xFF -> start 8 clocks low, then 8 data bits + 16 clocks high. busy=1 for 88 clocks.
- UART_TX_PARITY_EN defined, parity_odd=0, send 0x07 -> parity bit 1. With parity_odd=1 -> parity bit 0. Frame spans 88 clocks.
- Loopback tx_line into the team's UART receiver (same div_ratio), 256 random bytes back-to-back -> every byte received with valid=1, err=0, in order.
